adc_sample_avg_fifo: RTL and testbench
======================================

Name: adc_sample_avg_fifo

Overview:
- Consumes the 18-bit conversion results and the one-cycle ready strobe from the AD7960 serial controller, in the 100 MHz timing domain.
- Optionally averages 2^LOG2_AVG consecutive samples (block decimation), or passes each sample through unchanged.
- Buffers the results in a first-word-fall-through FIFO with a valid/ready output, for the downstream packetiser/host interface.
- Reports FIFO occupancy and keeps a sticky overrun flag.

Parameters:
DATA_W, 18, sample width; samples are two's complement.
LOG2_AVG, 2, log2 of the averaging block length (1..6).
FIFO_AW, 4, FIFO address width; depth is 2^FIFO_AW = 16.

Ports:
m_clk_i  in  1  100 MHz clock; all logic on its rising edge.
buffer_reset_s  in  1  reset, asynchronous, active-high.
sample_rdy_i  in  1  sample strobe; each cycle it is high is one sample.
sample_i  in  DATA_W  sample value, valid while sample_rdy_i=1.
avg_en_i  in  1  1 = average mode, 0 = bypass; quasi-static.
m_data_o  out  DATA_W  FIFO head; forced to 0 while m_valid_o=0.
m_valid_o  out  1  FIFO not empty.
m_ready_i  in  1  consumer accepts the head when m_valid_o=1 and m_ready_i=1.
fifo_level_o  out  FIFO_AW+1  entries held, 0..16.
overrun_o  out  1  sticky; set when a result is dropped because the FIFO is full.
clear_overrun_i  in  1  synchronous clear for overrun_o.

Behaviour:
Reset (asynchronous, any time, including mid-block or mid-drain):
- Accumulator and block counter clear.
- FIFO pointers and level clear; stored words are discarded.
- Output values: m_valid_o=0, m_data_o=0, fifo_level_o=0, overrun_o=0.
- The registered mode is set to avg_en_i as sampled at the first clock after reset.

Average mode:
- Accumulator is signed, width DATA_W+LOG2_AVG; it cannot overflow.
- Block counter runs 0..2^LOG2_AVG-1.
- On a strobe with count < max: acc <= acc + sext(sample_i); count increments.
- On a strobe with count = max: result = (acc + sext(sample_i)) >>> LOG2_AVG. The shift is arithmetic, so the result truncates toward -inf. acc <= 0, count <= 0.
- The result is presented for a FIFO write in the same cycle. It appears at m_data_o (if the FIFO was empty) one clock after the final strobe.

Bypass mode:
- sample_i is presented for a FIFO write on each strobe.
- Same one-clock latency to m_data_o.

Mode change:
- avg_en_i is registered each cycle.
- If the registered mode differs from its previous value, acc and count clear and the partial block is discarded.
- A strobe in the same cycle as a mode change starts the new block under the new mode.

FIFO:
- Write: a result is written if level < 16, or if level = 16 and a read occurs in the same cycle. With a simultaneous read and write, level is unchanged.
- Full: if level = 16 and no read, the result is dropped and overrun_o <= 1.
- Read: when m_valid_o and m_ready_i are both 1, the head pops; the next word is visible on the following cycle.
- Empty with simultaneous write: the written word becomes visible next cycle. There is no same-cycle bypass.
- Pointers wrap modulo 16. Word order is strictly preserved.
- overrun_o: clear_overrun_i clears it. If a clear and a new drop occur in the same cycle, set wins.
- m_valid_o = (level != 0). fifo_level_o is registered.

Timing assumptions:
- The upstream strobe period is 20 clocks. The block must nevertheless accept strobes on consecutive cycles.

Test Plan:
1. Average LOG2_AVG=2, strobes with 100, 101, 102, 103, m_ready_i=1 -> a single output 101 (0x00065), m_valid_o high for 1 cycle, one clock after the 4th strobe.
2. Negative rounding: -1, -2, -2, -2 -> sum -7, output -2 (0x3FFFE). Extremes: 4×0x1FFFF -> 0x1FFFF; 4×0x20000 -> 0x20000.
3. Bypass: avg_en_i=0, samples 5, 0x3FFFF, 7 -> three outputs in the same order, each one clock after its strobe.
4. Overflow: m_ready_i=0, bypass, 20 strobes with values 0..19.
   - fifo_level_o saturates at 16.
   - overrun_o rises on the 17th strobe and stays high.
   - Draining yields 0..15.
   - clear_overrun_i then drops overrun_o.
5. Full with simultaneous read: level 16, strobe and pop in the same cycle -> write accepted, level stays 16, overrun_o stays 0.
6. Mid-block disruption:
   - 2 samples (50, 60), then assert buffer_reset_s for 1 cycle, then 8, 8, 8, 8 -> output 8 only. All outputs read 0 during reset.
   - Repeat with an avg_en_i toggle instead of reset -> the partial block is discarded.

Source files
------------

// File: rtl/adc_sample_avg_fifo_if.sv
// Output stream of the ADC sample path: FIFO head with valid/ready handshake.
interface adc_sample_avg_fifo_if #(
  parameter int DATA_W = 18
);
  logic [DATA_W-1:0] m_data_o;
  logic              m_valid_o;
  logic              m_ready_i;

  modport master (output m_data_o, output m_valid_o, input  m_ready_i);
  modport slave  (input  m_data_o, input  m_valid_o, output m_ready_i);
endinterface

// File: rtl/adc_sample_avg_fifo.sv
// AD7960 sample conditioner: optional 2^LOG2_AVG block averaging followed by a
// first-word-fall-through FIFO with occupancy and a sticky overrun flag.
module adc_sample_avg_fifo #(
  parameter int DATA_W   = 18,
  parameter int LOG2_AVG = 2,
  parameter int FIFO_AW  = 4
) (
  input  logic                  m_clk_i,
  input  logic                  buffer_reset_s,
  input  logic                  sample_rdy_i,
  input  logic [DATA_W-1:0]     sample_i,
  input  logic                  avg_en_i,
  adc_sample_avg_fifo_if.master m_if,
  output logic [FIFO_AW:0]      fifo_level_o,
  output logic                  overrun_o,
  input  logic                  clear_overrun_i
);

  localparam int                  ACC_W    = DATA_W + LOG2_AVG;
  localparam int                  DEPTH    = 1 << FIFO_AW;
  localparam logic [LOG2_AVG-1:0] CNT_MAX  = '1;
  localparam logic [FIFO_AW:0]    FULL_LVL = (FIFO_AW + 1)'(DEPTH);

  // Mode tracking
  logic mode_q, mode_d;
  logic prev_q, prev_d;
  logic init_q, init_d;
  logic mode_chg;

  // Averager
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_base, sample_sx, sum;
  logic [LOG2_AVG-1:0]     cnt_q, cnt_d, cnt_base;
  logic                    res_vld;
  logic [DATA_W-1:0]       res_data;

  // FIFO
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               overrun_q, overrun_d;
  logic               valid, rd_en, wr_en, drop, full;

  // prev_q tracks mode_q one cycle late; on the first clock after reset both
  // load avg_en_i so the initial mode does not count as a change.
  always_comb begin
    mode_d   = avg_en_i;
    prev_d   = init_q ? mode_q : avg_en_i;
    init_d   = 1'b1;
    mode_chg = (mode_q != prev_q);
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    acc_base  = mode_chg ? '0 : acc_q;
    cnt_base  = mode_chg ? '0 : cnt_q;
    sample_sx = {{LOG2_AVG{sample_i[DATA_W-1]}}, sample_i};
    sum       = acc_base + sample_sx;
    acc_d     = acc_base;
    cnt_d     = cnt_base;
    res_vld   = 1'b0;
    res_data  = sample_i;
    if (sample_rdy_i) begin
      if (!mode_q) begin
        res_vld = 1'b1;
      end else if (cnt_base == CNT_MAX) begin
        // Upper slice of the signed sum == sum >>> LOG2_AVG (floor division).
        res_vld  = 1'b1;
        res_data = sum[ACC_W-1:LOG2_AVG];
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_base + LOG2_AVG'(1);
      end
    end
  end

  always_comb begin
    valid     = (level_q != '0);
    full      = (level_q == FULL_LVL);
    rd_en     = valid && m_if.m_ready_i;
    wr_en     = res_vld && (!full || rd_en);
    drop      = res_vld && full && !rd_en;
    wr_ptr_d  = wr_en ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d  = rd_en ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    level_d   = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
      default: level_d = level_q;
    endcase
    // A new drop outranks a clear in the same cycle.
    overrun_d = drop ? 1'b1 : (clear_overrun_i ? 1'b0 : overrun_q);
  end

  always_ff @(posedge m_clk_i or posedge buffer_reset_s) begin
    if (buffer_reset_s) begin
      mode_q    <= 1'b0;
      prev_q    <= 1'b0;
      init_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      prev_q    <= prev_d;
      init_q    <= init_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: storage is deliberately not reset; the zero level hides stale words
  // and the head is forced to 0 while empty.
  always_ff @(posedge m_clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= res_data;
  end

  assign m_if.m_valid_o = valid;
  assign m_if.m_data_o  = valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level_o   = level_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_adc_sample_avg_fifo.sv
// Directed bench for adc_sample_avg_fifo: averaging, bypass, overflow, full
// with simultaneous pop, and mid-block reset / mode-toggle disruption.
module tb_adc_sample_avg_fifo;

  localparam int DATA_W = 18;

  logic              m_clk_i = 1'b0;
  logic              buffer_reset_s;
  logic              sample_rdy_i;
  logic [DATA_W-1:0] sample_i;
  logic              avg_en_i;
  logic [4:0]        fifo_level_o;
  logic              overrun_o;
  logic              clear_overrun_i;

  int compared   = 0;
  int mismatched = 0;

  adc_sample_avg_fifo_if #(.DATA_W(DATA_W)) m_if ();

  adc_sample_avg_fifo #(.DATA_W(DATA_W), .LOG2_AVG(2), .FIFO_AW(4)) dut (
    .m_clk_i         (m_clk_i),
    .buffer_reset_s  (buffer_reset_s),
    .sample_rdy_i    (sample_rdy_i),
    .sample_i        (sample_i),
    .avg_en_i        (avg_en_i),
    .m_if            (m_if.master),
    .fifo_level_o    (fifo_level_o),
    .overrun_o       (overrun_o),
    .clear_overrun_i (clear_overrun_i)
  );

  always #5 m_clk_i = ~m_clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge m_clk_i);
    #1;
  endtask

  task automatic strobe(input logic [DATA_W-1:0] val);
    sample_rdy_i = 1'b1;
    sample_i     = val;
    step();
    sample_rdy_i = 1'b0;
    sample_i     = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_out(input string tag, input logic v, input logic [DATA_W-1:0] d);
    check({tag, ".valid"}, 32'(m_if.m_valid_o), 32'(v));
    check({tag, ".data"},  32'(m_if.m_data_o),  32'(d));
  endtask

  initial begin
    buffer_reset_s  = 1'b1;
    sample_rdy_i    = 1'b0;
    sample_i        = '0;
    avg_en_i        = 1'b1;
    clear_overrun_i = 1'b0;
    m_if.m_ready_i  = 1'b1;
    #1;
    check_out("reset", 1'b0, '0);
    check("reset.level",   32'(fifo_level_o), 32'd0);
    check("reset.overrun", 32'(overrun_o),    32'd0);
    idle(2);
    buffer_reset_s = 1'b0;
    idle(2);

    // 1: average of 100..103 -> 101
    strobe(18'd100); strobe(18'd101); strobe(18'd102);
    check_out("avg1.partial", 1'b0, '0);
    strobe(18'd103);
    check_out("avg1.out", 1'b1, 18'h00065);
    step();
    check_out("avg1.popped", 1'b0, '0);

    // 2: negative rounding toward -inf and extremes
    strobe(18'h3FFFF); strobe(18'h3FFFE); strobe(18'h3FFFE); strobe(18'h3FFFE);
    check_out("avg2.neg", 1'b1, 18'h3FFFE);
    step();
    for (int i = 0; i < 4; i++) strobe(18'h1FFFF);
    check_out("avg2.maxpos", 1'b1, 18'h1FFFF);
    step();
    for (int i = 0; i < 4; i++) strobe(18'h20000);
    check_out("avg2.maxneg", 1'b1, 18'h20000);
    step();
    check_out("avg2.empty", 1'b0, '0);

    // 3: bypass, each sample one clock after its strobe
    avg_en_i = 1'b0;
    idle(3);
    strobe(18'd5);
    check_out("byp.s0", 1'b1, 18'd5);
    strobe(18'h3FFFF);
    check_out("byp.s1", 1'b1, 18'h3FFFF);
    check("byp.level", 32'(fifo_level_o), 32'd1);
    strobe(18'd7);
    check_out("byp.s2", 1'b1, 18'd7);
    step();
    check_out("byp.empty", 1'b0, '0);

    // 4: overflow with consumer stalled
    m_if.m_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      strobe(DATA_W'(i));
      if (i == 15) begin
        check("ovf.level16",   32'(fifo_level_o), 32'd16);
        check("ovf.no_ovr16",  32'(overrun_o),    32'd0);
      end
      if (i == 16) check("ovf.ovr17", 32'(overrun_o), 32'd1);
    end
    check("ovf.level_sat", 32'(fifo_level_o), 32'd16);
    check("ovf.ovr_stuck", 32'(overrun_o),    32'd1);
    m_if.m_ready_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check_out($sformatf("ovf.drain%0d", k), 1'b1, DATA_W'(k));
      step();
    end
    check_out("ovf.drained", 1'b0, '0);
    check("ovf.level0",   32'(fifo_level_o), 32'd0);
    check("ovf.ovr_hold", 32'(overrun_o),    32'd1);
    clear_overrun_i = 1'b1;
    step();
    clear_overrun_i = 1'b0;
    check("ovf.cleared", 32'(overrun_o), 32'd0);

    // 5: full FIFO, strobe and pop in the same cycle
    m_if.m_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) strobe(DATA_W'(18'h100 + i));
    check("full.level", 32'(fifo_level_o), 32'd16);
    m_if.m_ready_i = 1'b1;
    strobe(18'h00ABC);
    m_if.m_ready_i = 1'b0;
    check("full.level_kept", 32'(fifo_level_o), 32'd16);
    check("full.no_ovr",     32'(overrun_o),    32'd0);
    check_out("full.head", 1'b1, 18'h101);
    m_if.m_ready_i = 1'b1;
    idle(15);
    check_out("full.last", 1'b1, 18'h00ABC);
    step();
    check_out("full.empty", 1'b0, '0);

    // 6a: reset mid-block and with data buffered
    avg_en_i = 1'b1;
    idle(3);
    m_if.m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) strobe(18'd20);
    check_out("rst.buffered", 1'b1, 18'd20);
    strobe(18'd50); strobe(18'd60);
    buffer_reset_s = 1'b1;
    #1;
    check_out("rst.during", 1'b0, '0);
    check("rst.level", 32'(fifo_level_o), 32'd0);
    check("rst.ovr",   32'(overrun_o),    32'd0);
    step();
    buffer_reset_s = 1'b0;
    m_if.m_ready_i = 1'b1;
    idle(2);
    strobe(18'd8); strobe(18'd8);
    check_out("rst.no_stale2", 1'b0, '0);
    strobe(18'd8);
    check_out("rst.no_stale3", 1'b0, '0);
    strobe(18'd8);
    check_out("rst.out", 1'b1, 18'd8);
    step();

    // 6b: mode toggle mid-block discards the partial block
    strobe(18'd50); strobe(18'd60);
    avg_en_i = 1'b0;
    idle(2);
    avg_en_i = 1'b1;
    idle(3);
    check_out("tog.quiet", 1'b0, '0);
    strobe(18'd8); strobe(18'd8);
    check_out("tog.no_stale2", 1'b0, '0);
    strobe(18'd8);
    check_out("tog.no_stale3", 1'b0, '0);
    strobe(18'd8);
    check_out("tog.out", 1'b1, 18'd8);
    step();
    check_out("tog.empty", 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
